// File: rtl/dmem_uart_tx_pkg.sv
// Shared definitions for the data-memory mapped UART transmitter:
// register offsets, STATUS bit positions, FSM state encoding.
package risc_uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // A divider of zero still yields a one-clock bit.
  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/dmem_uart_tx_if.sv
// Data-memory port slice seen by the UART responder:
// decode hit, offset, store strobe/data and combinational load data.
interface dmem_uart_tx_if;

  logic        SEL;
  logic [3:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (
    output SEL, A, WE, WD,
    input  RD
  );

  modport slave (
    input  SEL, A, WE, WD,
    output RD
  );

endinterface

// File: rtl/dmem_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          drop
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rp_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & ~do_push;
    wp_d    = do_push ? wp_q + AW'(1) : wp_q;
    rp_d    = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q] <= wdata;
    end
  end

endmodule

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port.
// Define UART_TX_PARITY_EN to insert an even-parity bit after DATA.
module dmem_uart_tx
  import risc_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_uart_tx_if.slave  bus,
  output logic           TX,
  output logic           IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_tx, hit_st, hit_bd;
  logic          push, w1c, bd_we;
  logic          pop;
  logic [7:0]    f_rdata;
  logic          f_full, f_empty, f_drop;
  logic [CW-1:0] f_count;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, cnt_nx;
  logic [15:0]   per_q, per_d;
  logic [15:0]   baud_q, baud_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          bit_end;
  logic [31:0]   status;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.WD[31:16], bus.A[1:0]};

  always_comb begin
    hit_tx = bus.SEL & (bus.A[3:2] == OFF_TXDATA[3:2]);
    hit_st = bus.SEL & (bus.A[3:2] == OFF_STATUS[3:2]);
    hit_bd = bus.SEL & (bus.A[3:2] == OFF_BAUDDIV[3:2]);
    push   = hit_tx & bus.WE;
    w1c    = hit_st & bus.WE & bus.WD[ST_OVF];
    bd_we  = hit_bd & bus.WE;
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata (bus.WD[7:0]),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count),
    .drop  (f_drop)
  );

  // Dropped push wins over a same-cycle clear.
  always_comb begin
    ovf_d  = (ovf_q & ~w1c) | f_drop;
    baud_d = bd_we ? bus.WD[15:0] : baud_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == 16'd0);
    cnt_nx  = bit_end ? per_q - 16'd1 : cnt_q - 16'd1;

    unique case (state_q)
      IDLE: begin
        pop = ~f_empty;
      end
      START: begin
        cnt_d = cnt_nx;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        cnt_d = cnt_nx;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_nx;
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_nx;
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          pop     = ~f_empty;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start, from IDLE or straight out of STOP.
    if (pop) begin
      state_d = START;
      shift_d = f_rdata;
      per_d   = eff_div(baud_q);
      cnt_d   = eff_div(baud_q) - 16'd1;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^f_rdata;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= 16'd1;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      baud_q  <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_BUSY]          = (state_q != IDLE);
    status[ST_FULL]          = f_full;
    status[ST_EMPTY]         = f_empty;
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LO +: 4]   = 4'(f_count);
    bus.RD = '0;
    unique case (1'b1)
      hit_st:  bus.RD = status;
      hit_bd:  bus.RD = {16'h0, baud_q};
      default: bus.RD = '0;
    endcase
  end

  assign TX  = tx_q;
  assign IRQ = f_empty & (state_q == IDLE);

endmodule

// File: doc/dmem_uart_tx.md
# dmem_uart_tx

Memory-mapped UART transmitter that acts as a responder on the processor's data-memory port. It sits beside the data memory, and the top-level address decode steers stores and loads to it. Stored bytes enter a small FIFO and are serialized 8N1, LSB first, at a programmable bit period. Loads return status and configuration with the same combinational read timing as the data memory, so the single-cycle core needs no stall logic.

## Interface
Parameters:
- FIFO_DEPTH, default 4: TX FIFO entries, a power of two, at least 2.
- DEFAULT_DIV, default 16'd868: reset value of BAUDDIV, in clocks per bit.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SEL  in  1  address-decode hit for this peripheral's 16-byte window.
- A  in  4  byte offset within the window; A[1:0] is ignored.
- WE  in  1  store strobe, qualified by SEL.
- WD  in  32  store data.
- RD  out  32  load data, combinational from SEL/A and current state.
- TX  out  1  serial line, idle high.
- IRQ  out  1  level, high while the FIFO is empty and the shifter is idle.

## Operation
Register map by offset:
- 0x0 TXDATA: a write pushes WD[7:0]. Reads return 0.
- 0x4 STATUS: read-only except bit 3, which is write-1-to-clear.
  - bit0 busy: FSM not in IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow, sticky.
  - bits[7:4] FIFO count.
  - other bits 0.
- 0x8 BAUDDIV: R/W, bits[15:0]; upper bits read 0.
- 0xC: reserved. Reads return 0 and writes are ignored.

General access rules:
- When SEL=0, RD=0 and writes are ignored. Reads have no side effects.

FIFO:
- Push when SEL & WE & A=0x0.
- A push while full is dropped and sets overflow.
- A push and a pop in the same cycle while full are both accepted, and the count is unchanged.

FSM states: IDLE → START → DATA → STOP → IDLE, plus a PARITY state between DATA and STOP when parity is compiled in.
- IDLE: when the FIFO is non-empty, pop the head into an 8-bit shift register, latch BAUDDIV into the bit counter, and go to START.
- START: drive TX=0.
- DATA: drive TX from shift[0]. Shift right at each bit end. A 3-bit index counts 8 bits.
- STOP: drive TX=1. At bit end, go to IDLE. If the FIFO is non-empty at that edge, pop and enter START directly with no idle gap.
- Bit period: max(latched DIV, 1) clocks. The DIV value is latched per frame, so writing BAUDDIV mid-frame affects only the next frame.

## Timing
Reset values:
- TX=1, IRQ=1, FSM=IDLE.
- FIFO empty, count=0, overflow=0, BAUDDIV=DEFAULT_DIV.
- RD follows the reset state combinationally.

Latency:
- A push at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1. TX is low from edge N+1 until edge N+1+P, where P is the bit period.
- A frame is 10·P clocks, or 11·P with parity.
- STATUS reflects a push or pop in the cycle after the edge that performed it.
- IRQ deasserts in the cycle after a push. It reasserts in the cycle after the final STOP bit ends with the FIFO empty.

Boundary behaviour:
- RST asserted mid-frame: at that edge TX returns high and FIFO contents are discarded. No partial byte resumes.
- Overflow and W1C write in the same cycle: overflow stays set (set wins).

## Configuration
- UART_TX_PARITY_EN defined: a PARITY state is inserted after DATA. TX = even parity (XOR of the 8 data bits) for one bit period. Frame is 11·P.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic. Frame is 10·P.
- The register map is identical in both builds.

## Structure
- Package risc_uart_pkg holds:
  - the offset constants OFF_TXDATA, OFF_STATUS, OFF_BAUDDIV;
  - the STATUS bit indices;
  - the FSM state enum, including PARITY.
- One sub-module, uart_tx_fifo: parameterized by FIFO_DEPTH, with push/pop/data/full/empty/count. It handles simultaneous push and pop as specified above.
- Address decode producing SEL stays in the processor top level.

## Test plan
- DIV=4, store 0x55 to 0x0: TX = 0,1,0,1,0,1,0,1,0,1, each level lasting 4 clocks, for 40 clocks total. busy is 1 throughout, then IRQ returns to 1.
- DIV=2, five back-to-back stores 0x01–0x05 while idle: the first pops immediately and four fill the FIFO, so full=1 and overflow=0. A sixth store sets overflow=1. Five frames are sent with no idle gap between them.
- Write STATUS with WD=0x8: overflow clears. A store and an overflow-setting push in the same cycle leave overflow=1.
- Write BAUDDIV=8 in the middle of a DIV=4 frame: the current frame keeps 4-clock bits and the next frame uses 8-clock bits. Reading 0x8 returns 0x00000008.
- Assert RST for 1 cycle midway through the DATA bits with 2 bytes queued: TX=1, count=0 and IRQ=1 on the next cycle, and no further frames are sent.
- With UART_TX_PARITY_EN defined, DIV=3, store 0x07: the parity bit is 1 and lasts 3 clocks. The frame totals 33 clocks.
